// File: rtl/audio_tone_source.sv
// Audio tone source for the HDMI audio input, clocked entirely by clk_pixel.
// A fractional divider produces clk_audio at AUDIO_RATE with no long-term drift.
// Two phase-accumulator tone generators (left/right) are scaled by a gain that
// ramps one step per sample, which avoids clicks on enable, disable and volume change.
//
// Handshake: there is no backpressure. sample_strobe is a one-cycle valid pulse
// that marks new data on audio_sample_word. The word then holds until the next
// pulse. It changes in the cycle after clk_audio falls, so it is stable for half
// an audio period before the consumer's clk_audio rising edge.
module audio_tone_source #(
   parameter int CLKFRQ_HZ  = 74_250_000,
   parameter int AUDIO_RATE = 48000,
   parameter int BIT_WIDTH  = 16
) (
   input  logic                      clk_pixel,
   input  logic                      sys_resetn,
   input  logic                      enable,
   input  logic [1:0]                wave_sel,
   input  logic [7:0]                volume,
   input  logic [15:0]               freq_word_l,
   input  logic [15:0]               freq_word_r,
   output logic                      clk_audio,
   output logic                      sample_strobe,
   output logic [1:0][BIT_WIDTH-1:0] audio_sample_word,
   output logic                      busy,
   output logic [1:0]                dbg_state
);

   localparam logic [31:0] ACC_INC = 32'(2 * AUDIO_RATE);
   localparam logic [31:0] ACC_LIM = 32'(CLKFRQ_HZ);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RUN       = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] acc;
   logic [31:0] acc_sum;
   logic        wrap;
   logic        tick;
   logic [7:0]  gain;
   logic [7:0]  target;
   logic [7:0]  gain_step;
   logic        phase_clear;
   logic [15:0] phase_l, phase_r;

   // Raw waveform value for a 16-bit phase.
   function automatic logic signed [15:0] raw_sample(input logic [15:0] p, input logic [1:0] sel);
      logic [14:0]        mag;
      logic signed [16:0] tri_v;
      mag   = p[15] ? ~p[14:0] : p[14:0];
      tri_v = $signed({1'b0, mag, 1'b0}) - 17'sd32767;
      case (sel)
         2'd0:    raw_sample = p[15] ? 16'sh8001 : 16'sh7FFF;
         2'd1:    raw_sample = $signed({~p[15], p[14:0]});
         2'd2:    raw_sample = tri_v[15:0];
         default: raw_sample = 16'sd0;
      endcase
   endfunction

   // Multiply by unsigned gain, arithmetic shift right by 8, truncate.
   function automatic logic [BIT_WIDTH-1:0] scale(input logic signed [15:0] raw, input logic [7:0] g);
      logic signed [24:0] raw_x;
      logic signed [24:0] g_x;
      logic signed [24:0] prod;
      logic signed [24:0] shifted;
      raw_x   = 25'(raw);
      g_x     = $signed({17'd0, g});
      prod    = raw_x * g_x;
      shifted = prod >>> 8;
      scale   = shifted[BIT_WIDTH-1:0];
   endfunction

   assign acc_sum = acc + ACC_INC;
   assign wrap    = (acc_sum >= ACC_LIM);
   // The update tick is the wrap that takes clk_audio from 1 to 0.
   assign tick    = wrap & clk_audio;

   // Fractional divider: accumulate 2*AUDIO_RATE and toggle clk_audio on each wrap.
   always_ff @(posedge clk_pixel) begin
      if (!sys_resetn) begin
         acc       <= 32'd0;
         clk_audio <= 1'b0;
      end else if (wrap) begin
         acc       <= acc_sum - ACC_LIM;
         clk_audio <= ~clk_audio;
      end else begin
         acc       <= acc_sum;
      end
   end

   // Gain moves one step toward the target each tick and never overshoots.
   always_comb begin
      target    = enable ? volume : 8'd0;
      gain_step = gain;
      if (gain < target)
         gain_step = gain + 8'd1;
      else if (gain > target)
         gain_step = gain - 8'd1;
   end

   // FSM state register; it advances only on update ticks.
   always_ff @(posedge clk_pixel) begin
      if (!sys_resetn)
         state <= ST_IDLE;
      else if (tick)
         state <= state_n;
   end

   // Next-state logic, evaluated against the gain after this tick's step.
   always_comb begin
      state_n     = state;
      phase_clear = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && (volume != 8'd0))
               state_n = ST_RAMP_UP;
         end
         ST_RAMP_UP: begin
            if (!enable)
               state_n = ST_RAMP_DOWN;
            else if (gain_step == volume)
               state_n = ST_RUN;
            else if (volume < gain_step)
               state_n = ST_RAMP_DOWN;
         end
         ST_RUN: begin
            if (!enable || (volume < gain_step))
               state_n = ST_RAMP_DOWN;
            else if (volume > gain_step)
               state_n = ST_RAMP_UP;
         end
         ST_RAMP_DOWN: begin
            if (!enable) begin
               if (gain_step == 8'd0)
                  state_n = ST_IDLE;
            end else if (gain_step == volume) begin
               state_n     = ST_RUN;
               phase_clear = 1'b1;
            end else if (volume > gain_step) begin
               state_n = ST_RAMP_UP;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (state_n == ST_IDLE)
         phase_clear = 1'b1;
   end

   // Datapath: on each tick, step the gain, advance the phases and load new samples.
   always_ff @(posedge clk_pixel) begin
      if (!sys_resetn) begin
         sample_strobe     <= 1'b0;
         gain              <= 8'd0;
         phase_l           <= 16'd0;
         phase_r           <= 16'd0;
         audio_sample_word <= '0;
      end else begin
         sample_strobe <= tick;
         if (tick) begin
            gain <= gain_step;
            if (state_n == ST_IDLE) begin
               audio_sample_word <= '0;
            end else begin
               audio_sample_word[1] <= scale(raw_sample(phase_l, wave_sel), gain_step);
               audio_sample_word[0] <= scale(raw_sample(phase_r, wave_sel), gain_step);
            end
            phase_l <= phase_clear ? 16'd0 : phase_l + freq_word_l;
            phase_r <= phase_clear ? 16'd0 : phase_r + freq_word_r;
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_audio_tone_source.sv
// Bench for audio_tone_source with a scaled-down clock so the full ramps fit in
// a short run. The reference keeps the divider in closed form (toggle count =
// floor(n*2*AUDIO_RATE/CLKFRQ_HZ)) and the tone/gain behaviour as per-sample rules.
module tb_audio_tone_source;

   localparam int CLK_HZ = 100;
   localparam int RATE   = 7;
   localparam int INC    = 2 * RATE;
   localparam int LO     = CLK_HZ / INC;
   localparam int HI     = LO + 1;

   localparam int M_IDLE = 0;
   localparam int M_UP   = 1;
   localparam int M_RUN  = 2;
   localparam int M_DOWN = 3;

   // ---------------- clock / reset / DUT ----------------
   logic              clk_pixel = 1'b0;
   logic              sys_resetn;
   logic              enable;
   logic [1:0]        wave_sel;
   logic [7:0]        volume;
   logic [15:0]       freq_word_l, freq_word_r;
   logic              clk_audio;
   logic              sample_strobe;
   logic [1:0][15:0]  audio_sample_word;
   logic              busy;
   logic [1:0]        dbg_state;

   always #5 clk_pixel = ~clk_pixel;

   audio_tone_source #(
      .CLKFRQ_HZ (CLK_HZ),
      .AUDIO_RATE(RATE),
      .BIT_WIDTH (16)
   ) dut (
      .clk_pixel        (clk_pixel),
      .sys_resetn       (sys_resetn),
      .enable           (enable),
      .wave_sel         (wave_sel),
      .volume           (volume),
      .freq_word_l      (freq_word_l),
      .freq_word_r      (freq_word_r),
      .clk_audio        (clk_audio),
      .sample_strobe    (sample_strobe),
      .audio_sample_word(audio_sample_word),
      .busy             (busy),
      .dbg_state        (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint n_cyc;
   int     m_clk, m_strobe, m_mode, m_gain, m_ph_l, m_ph_r, m_l, m_r;

   function automatic int wave_value(input int p, input int sel);
      case (sel)
         0:       return (p >= 32768) ? -32767 : 32767;
         1:       return p - 32768;
         2:       return (p >= 32768) ? (65535 - p) * 2 - 32767 : p * 2 - 32767;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      n_cyc = 0; m_clk = 0; m_strobe = 0; m_mode = M_IDLE;
      m_gain = 0; m_ph_l = 0; m_ph_r = 0; m_l = 0; m_r = 0;
   endtask

   task automatic model_tick();
      int tgt, g, nm;
      bit restart;
      tgt = enable ? int'(volume) : 0;
      g   = m_gain;
      if (tgt > g) g++;
      else if (tgt < g) g--;
      nm = m_mode;
      restart = 0;
      case (m_mode)
         M_IDLE: if (enable && volume != 0) nm = M_UP;
         M_UP: begin
            if (!enable) nm = M_DOWN;
            else if (g == int'(volume)) nm = M_RUN;
            else if (int'(volume) < g) nm = M_DOWN;
         end
         M_RUN: begin
            if (!enable || int'(volume) < g) nm = M_DOWN;
            else if (int'(volume) > g) nm = M_UP;
         end
         default: begin
            if (!enable) begin
               if (g == 0) nm = M_IDLE;
            end else if (g == int'(volume)) begin
               nm = M_RUN; restart = 1;
            end else if (int'(volume) > g) begin
               nm = M_UP;
            end
         end
      endcase
      m_gain = g;
      m_mode = nm;
      if (nm == M_IDLE) begin
         m_l = 0; m_r = 0; m_ph_l = 0; m_ph_r = 0;
      end else begin
         m_l = (wave_value(m_ph_l, int'(wave_sel)) * g) >>> 8;
         m_r = (wave_value(m_ph_r, int'(wave_sel)) * g) >>> 8;
         m_ph_l = restart ? 0 : (m_ph_l + int'(freq_word_l)) % 65536;
         m_ph_r = restart ? 0 : (m_ph_r + int'(freq_word_r)) % 65536;
      end
   endtask

   // ---------------- per-cycle step with timing checks ----------------
   int prev_clk = 0, prev_l = 0, prev_r = 0;
   int stable_cnt = 0, half_cnt = 0, rise_cnt = 0;
   bit half_valid = 0;

   task automatic step();
      longint t_new, t_old;
      bit rst_now;
      int obs_l, obs_r;
      bit rose, changed;
      @(posedge clk_pixel);
      rst_now = !sys_resetn;
      if (rst_now) begin
         model_reset();
      end else begin
         n_cyc++;
         t_new    = (n_cyc * INC) / CLK_HZ;
         t_old    = ((n_cyc - 1) * INC) / CLK_HZ;
         m_clk    = int'(t_new % 2);
         m_strobe = (t_new != t_old) && (t_new % 2 == 0);
         if (m_strobe) model_tick();
      end
      @(negedge clk_pixel);
      obs_l = int'($signed(audio_sample_word[1]));
      obs_r = int'($signed(audio_sample_word[0]));
      check("clk_audio", int'(clk_audio), m_clk);
      check("sample_strobe", int'(sample_strobe), m_strobe);
      check("busy", int'(busy), int'(m_mode != M_IDLE));
      check("left", obs_l, m_l);
      check("right", obs_r, m_r);
      if (!rst_now) begin
         changed = (obs_l != prev_l) || (obs_r != prev_r);
         rose    = clk_audio && (prev_clk == 0);
         if (changed) begin
            check("change_needs_strobe", int'(sample_strobe), 1);
            check("change_on_rise", int'(rose), 0);
            stable_cnt = 0;
         end else begin
            stable_cnt++;
         end
         if (rose) begin
            rise_cnt++;
            check("stable_before_rise", int'(stable_cnt >= LO), 1);
         end
         if (int'(clk_audio) != prev_clk) begin
            if (half_valid) check("half_len", int'(half_cnt == LO || half_cnt == HI), 1);
            half_valid = 1;
            half_cnt   = 1;
         end else begin
            half_cnt++;
         end
      end else begin
         stable_cnt = 0; half_cnt = 0; half_valid = 0;
      end
      prev_clk = int'(clk_audio);
      prev_l   = obs_l;
      prev_r   = obs_r;
   endtask

   // Advance until the next sample_strobe, bounded.
   task automatic next_strobe();
      for (int i = 0; i < 4 * HI + 4; i++) begin
         step();
         if (sample_strobe) return;
      end
      check("strobe_timeout", 0, 1);
   endtask

   task automatic pulse_reset();
      sys_resetn = 1'b0;
      step();
      check("rst_clk_audio", int'(clk_audio), 0);
      check("rst_strobe", int'(sample_strobe), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_left", int'(audio_sample_word[1]), 0);
      check("rst_right", int'(audio_sample_word[0]), 0);
      sys_resetn = 1'b1;
   endtask

   // Global time limit so a stuck run still ends.
   initial begin
      #(2_000_000);
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int ticks, smax, smin, cur_l, cur_r, first_n;
      bit done;
      model_reset();
      sys_resetn = 1'b0; enable = 1'b0; wave_sel = 2'd0; volume = 8'd0;
      freq_word_l = 16'd0; freq_word_r = 16'd0;
      repeat (3) step();
      check("reset_clk_audio", int'(clk_audio), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_word", int'(audio_sample_word), 0);

      // 1: divider rate over 10 * CLK_HZ cycles
      sys_resetn = 1'b1;
      rise_cnt = 0;
      repeat (10 * CLK_HZ) step();
      check("rise_count", rise_cnt, 10 * RATE);

      // 2: ramp up on a square wave
      enable = 1'b1; volume = 8'd255; wave_sel = 2'd0;
      freq_word_l = 16'd1024; freq_word_r = 16'd1024;
      ticks = 0; done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         next_strobe();
         ticks++;
         cur_l = int'($signed(audio_sample_word[1]));
         if (cur_l == 32639 || cur_l == -32640) done = 1;
      end
      check("ramp_up_ticks", ticks, 255);
      check("busy_in_run", int'(busy), 1);
      smax = -100000; smin = 100000;
      for (int i = 0; i < 130; i++) begin
         next_strobe();
         cur_l = int'($signed(audio_sample_word[1]));
         if (cur_l > smax) smax = cur_l;
         if (cur_l < smin) smin = cur_l;
      end
      check("square_max", smax, 32639);
      check("square_min", smin, -32640);

      // 3: ramp down to idle
      enable = 1'b0;
      ticks = 0;
      for (int i = 0; i < 300 && busy; i++) begin
         next_strobe();
         ticks++;
      end
      check("ramp_down_ticks", ticks, 255);
      check("idle_busy", int'(busy), 0);
      check("idle_left", int'(audio_sample_word[1]), 0);
      check("idle_right", int'(audio_sample_word[0]), 0);

      // 4: sawtooth, phases restart from 0
      enable = 1'b1; volume = 8'd255; wave_sel = 2'd1;
      freq_word_l = 16'h4000; freq_word_r = 16'hC000;
      next_strobe();
      check("saw_first_left", int'($signed(audio_sample_word[1])), -128);
      check("saw_first_right", int'($signed(audio_sample_word[0])), -128);
      repeat (255) next_strobe();
      for (int i = 0; i < 8; i++) begin
         cur_l = int'($signed(audio_sample_word[1]));
         cur_r = int'($signed(audio_sample_word[0]));
         next_strobe();
         check("saw_left_seq", int'($signed(audio_sample_word[1])),
               (cur_l == 16320) ? -32640 : cur_l + 16320);
         check("saw_right_seq", int'($signed(audio_sample_word[0])),
               (cur_r == -32640) ? 16320 : cur_r - 16320);
      end

      // 5: reset mid-run, then mid-ramp-up; divider restarts
      pulse_reset();
      enable = 1'b1; volume = 8'd200; wave_sel = 2'd2;
      freq_word_l = 16'($urandom_range(0, 65535));
      freq_word_r = 16'($urandom_range(0, 65535));
      repeat (50) next_strobe();
      check("mid_ramp_busy", int'(busy), 1);
      pulse_reset();
      first_n = 0;
      for (int i = 0; i < 4 * HI + 4; i++) begin
         step();
         first_n++;
         if (sample_strobe) break;
      end
      check("first_tick_after_reset", first_n, (2 * CLK_HZ + INC - 1) / INC);
      repeat (30) next_strobe();

      // 6: randomized input changes at random times
      for (int k = 0; k < 300; k++) begin
         enable      = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) volume = 8'($urandom_range(0, 255));
         wave_sel    = 2'($urandom_range(0, 3));
         freq_word_l = 16'($urandom_range(0, 65535));
         freq_word_r = 16'($urandom_range(0, 65535));
         repeat ($urandom_range(1, 60)) step();
      end
      volume = 8'd0; enable = 1'b1;
      repeat (300) next_strobe();
      check("vol0_enabled_zero_left", int'(audio_sample_word[1]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
